dtw_multi_sched: RTL and testbench

DTW_MULTI_SCHED -- requirements
Module: dtw_multi_sched

---
 rtl/dtw_multi_sched_pkg.sv | 27 ++
 rtl/dtw_multi_sched_rr_pick.sv | 47 ++++
 rtl/dtw_multi_sched.sv | 202 ++++++++++++++++++++
 tb/tb_dtw_multi_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_multi_sched_pkg.sv
// -----------------------------------------------------------------------------
// dtw_multi_sched_pkg
// Shared definitions for the multi-core DTW query scheduler: dispatch and
// collect FSM state encodings, result packet length, and a width helper.
// -----------------------------------------------------------------------------
package dtw_multi_sched_pkg;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_START = 2'd1,
        D_XFER  = 2'd2
    } disp_state_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_XFER = 1'b1
    } coll_state_t;

    // A result packet is {qid, pos, min}.
    localparam int RES_WORDS = 3;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtw_multi_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-set finder. Starting at i_ptr and wrapping
// modulo N, returns the first index whose request bit is set.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [W-1:0]  search start index
//   o_found          some request bit is set
//   o_idx   [W-1:0]  first set index at or after i_ptr (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    // Index reached by stepping b places forward from a, wrapping at N.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input int b);
        int s;
        s = (int'(a) + b) % N;
        return W'(s);
    endfunction

    // Request vector rotated so that bit 0 corresponds to i_ptr.
    logic [N-1:0] w_rot;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_rot[gi] = i_req[wrap_add(i_ptr, gi)];
    end

    // Scan from the far end so the nearest request is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                o_idx   = wrap_add(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/dtw_multi_sched.sv
// -----------------------------------------------------------------------------
// dtw_multi_sched
// Dispatches query packets (1 qid word + SQG_SIZE samples) from one input
// stream to N_CORES DTW cores round-robin, and collects 3-word result packets
// from the cores' result FIFOs onto one output stream, round-robin, without
// interleaving packets.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_valid/s_ready/s_data         query word input stream
//   core_start[N]                  one-cycle run-start pulse per core
//   core_busy[N]                   per-core busy flag
//   core_src_wren[N], core_src_data  per-core source FIFO write (shared data)
//   core_src_full[N]               per-core source FIFO full
//   core_res_empty[N], core_res_rden[N], core_res_data[32N]  FWFT result FIFOs
//   m_valid/m_ready/m_data/m_last  result word output stream
//   n_dispatched                   count of fully dispatched queries
// -----------------------------------------------------------------------------
module dtw_multi_sched
    import dtw_multi_sched_pkg::*;
#(
    parameter int N_CORES  = 4,
    parameter int SQG_SIZE = 250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    output logic [N_CORES-1:0]   core_start,
    input  logic [N_CORES-1:0]   core_busy,
    output logic [N_CORES-1:0]   core_src_wren,
    input  logic [N_CORES-1:0]   core_src_full,
    output logic [31:0]          core_src_data,
    input  logic [N_CORES-1:0]   core_res_empty,
    output logic [N_CORES-1:0]   core_res_rden,
    input  logic [32*N_CORES-1:0] core_res_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_data,
    output logic                 m_last,
    output logic [31:0]          n_dispatched
);

    localparam int PW  = idx_width(N_CORES);
    localparam int WCW = idx_width(SQG_SIZE + 1);
    localparam int RCW = idx_width(RES_WORDS);

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] a);
        if (int'(a) == N_CORES - 1) return '0;
        return a + 1'b1;
    endfunction

    // ---------------- dispatch state ----------------
    disp_state_t          r_dstate, w_dstate_next;
    logic [PW-1:0]        r_dsel, w_dsel_next;
    logic [PW-1:0]        r_disp_ptr, w_disp_ptr_next;
    logic [WCW-1:0]       r_wcnt, w_wcnt_next;
    logic [31:0]          r_n_disp, w_n_disp_next;
    logic [N_CORES-1:0]   r_pending, w_pend_set;

    // ---------------- collect state ----------------
    coll_state_t          r_cstate, w_cstate_next;
    logic [PW-1:0]        r_csel, w_csel_next;
    logic [PW-1:0]        r_coll_ptr, w_coll_ptr_next;
    logic [RCW-1:0]       r_rcnt, w_rcnt_next;

    logic                 w_disp_found, w_coll_found;
    logic [PW-1:0]        w_disp_idx, w_coll_idx;
    logic                 w_in_xfer, w_s_hs, w_c_xfer, w_pop;
    logic [31:0]          w_res_word [N_CORES];

    // A core is eligible only once it has shown busy since its last start,
    // which keeps a slow-to-respond core from being started twice.
    rr_pick #(.N(N_CORES), .W(PW)) u_disp_pick (
        .i_req   (~core_busy & ~r_pending),
        .i_ptr   (r_disp_ptr),
        .o_found (w_disp_found),
        .o_idx   (w_disp_idx)
    );

    rr_pick #(.N(N_CORES), .W(PW)) u_coll_pick (
        .i_req   (~core_res_empty),
        .i_ptr   (r_coll_ptr),
        .o_found (w_coll_found),
        .o_idx   (w_coll_idx)
    );

    // All outputs are forced low during reset, even mid-packet.
    assign w_in_xfer     = !rst && (r_dstate == D_XFER);
    assign s_ready       = w_in_xfer && !core_src_full[r_dsel];
    assign w_s_hs        = s_ready && s_valid;
    assign core_src_data = w_in_xfer ? s_data : '0;

    assign w_c_xfer = !rst && (r_cstate == C_XFER);
    assign m_valid  = w_c_xfer && !core_res_empty[r_csel];
    assign m_data   = w_c_xfer ? w_res_word[r_csel] : '0;
    assign m_last   = w_c_xfer && (r_rcnt == RCW'(RES_WORDS - 1));
    assign w_pop    = m_valid && m_ready;

    assign n_dispatched = r_n_disp;

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
        assign w_res_word[gi]    = core_res_data[32*gi +: 32];
        assign core_start[gi]    = !rst && (r_dstate == D_START) && (r_dsel == PW'(gi));
        assign core_src_wren[gi] = w_s_hs && (r_dsel == PW'(gi));
        assign core_res_rden[gi] = w_pop && (r_csel == PW'(gi));
    end

    // ---------------- dispatch next-state ----------------
    always_comb begin
        w_dstate_next   = r_dstate;
        w_dsel_next     = r_dsel;
        w_disp_ptr_next = r_disp_ptr;
        w_wcnt_next     = r_wcnt;
        w_n_disp_next   = r_n_disp;
        w_pend_set      = '0;
        case (r_dstate)
            D_IDLE: begin
                if (w_disp_found) begin
                    w_dsel_next            = w_disp_idx;
                    w_pend_set[w_disp_idx] = 1'b1;
                    w_dstate_next          = D_START;
                end
            end
            D_START: begin
                w_wcnt_next   = '0;
                w_dstate_next = D_XFER;
            end
            D_XFER: begin
                if (w_s_hs) begin
                    // wcnt == SQG_SIZE marks the last of SQG_SIZE+1 words.
                    if (r_wcnt == WCW'(SQG_SIZE)) begin
                        w_disp_ptr_next = next_idx(r_dsel);
                        w_n_disp_next   = r_n_disp + 32'd1;
                        w_dstate_next   = D_IDLE;
                    end else begin
                        w_wcnt_next = r_wcnt + 1'b1;
                    end
                end
            end
            default: w_dstate_next = D_IDLE;
        endcase
    end

    // ---------------- collect next-state ----------------
    always_comb begin
        w_cstate_next   = r_cstate;
        w_csel_next     = r_csel;
        w_coll_ptr_next = r_coll_ptr;
        w_rcnt_next     = r_rcnt;
        case (r_cstate)
            C_IDLE: begin
                if (w_coll_found) begin
                    w_csel_next   = w_coll_idx;
                    w_rcnt_next   = '0;
                    w_cstate_next = C_XFER;
                end
            end
            C_XFER: begin
                // The grant is held until the whole packet has been popped.
                if (w_pop) begin
                    if (r_rcnt == RCW'(RES_WORDS - 1)) begin
                        w_coll_ptr_next = next_idx(r_csel);
                        w_cstate_next   = C_IDLE;
                    end else begin
                        w_rcnt_next = r_rcnt + 1'b1;
                    end
                end
            end
            default: w_cstate_next = C_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dstate   <= D_IDLE;
            r_dsel     <= '0;
            r_disp_ptr <= '0;
            r_wcnt     <= '0;
            r_n_disp   <= '0;
            r_pending  <= '0;
            r_cstate   <= C_IDLE;
            r_csel     <= '0;
            r_coll_ptr <= '0;
            r_rcnt     <= '0;
        end else begin
            r_dstate   <= w_dstate_next;
            r_dsel     <= w_dsel_next;
            r_disp_ptr <= w_disp_ptr_next;
            r_wcnt     <= w_wcnt_next;
            r_n_disp   <= w_n_disp_next;
            // Selection requires busy=0, so set and clear never collide.
            r_pending  <= (r_pending & ~core_busy) | w_pend_set;
            r_cstate   <= w_cstate_next;
            r_csel     <= w_csel_next;
            r_coll_ptr <= w_coll_ptr_next;
            r_rcnt     <= w_rcnt_next;
        end
    end

endmodule

// File: tb/tb_dtw_multi_sched.sv
// -----------------------------------------------------------------------------
// tb_dtw_multi_sched
// Directed scenarios with random payloads for dtw_multi_sched (4 cores,
// 4 samples per query). The bench emulates the cores' FIFOs with queues and
// scores the writes and collected words against its own packet records.
// -----------------------------------------------------------------------------
module tb_dtw_multi_sched;

    localparam int NC = 4;
    localparam int SQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_busy;
    logic [NC-1:0]     core_src_wren;
    logic [NC-1:0]     core_src_full;
    logic [31:0]       core_src_data;
    logic [NC-1:0]     core_res_empty;
    logic [NC-1:0]     core_res_rden;
    logic [32*NC-1:0]  core_res_data;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic              m_last;
    logic [31:0]       n_dispatched;

    dtw_multi_sched #(.N_CORES(NC), .SQG_SIZE(SQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .core_start     (core_start),
        .core_busy      (core_busy),
        .core_src_wren  (core_src_wren),
        .core_src_full  (core_src_full),
        .core_src_data  (core_src_data),
        .core_res_empty (core_res_empty),
        .core_res_rden  (core_res_rden),
        .core_res_data  (core_res_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .n_dispatched   (n_dispatched)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] wr_q  [NC][$];   // words written into each source FIFO
    logic [31:0] res_q [NC][$];   // emulated result FIFO contents
    logic [31:0] out_q [$];       // accepted output words
    logic        last_q[$];       // m_last of each accepted output word
    int          start_cnt[NC];
    int          wren_total;
    logic        acc;
    logic        smp_sready;
    logic [NC-1:0] pend_pop;
    logic [31:0] pkt [SQ+1];
    logic [31:0] res_a [3];
    logic [31:0] res_b [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NC; i++) begin
            core_res_empty[i]        = (res_q[i].size() == 0);
            core_res_data[32*i +: 32] = (res_q[i].size() == 0) ? 32'h0 : res_q[i][0];
        end
    endtask

    // One clock: observe at the falling edge, update emulated FIFOs after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc        = s_valid && s_ready;
        smp_sready = s_ready;
        chk("onehot_start", 32'($onehot0(core_start)), 32'd1);
        chk("onehot_wren",  32'($onehot0(core_src_wren)), 32'd1);
        chk("onehot_rden",  32'($onehot0(core_res_rden)), 32'd1);
        chk("wren_is_hs",   32'(|core_src_wren), 32'(acc));
        chk("rden_is_pop",  32'(|core_res_rden), 32'(m_valid && m_ready));
        for (int i = 0; i < NC; i++) begin
            if (core_start[i]) start_cnt[i]++;
            if (core_src_wren[i]) begin
                wr_q[i].push_back(core_src_data);
                wren_total++;
            end
        end
        if (|core_src_wren) chk("src_data", core_src_data, s_data);
        pend_pop = core_res_rden;
        if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            last_q.push_back(m_last);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++)
            if (pend_pop[i] && res_q[i].size() > 0) void'(res_q[i].pop_front());
        refresh();
    endtask

    task automatic clear_log();
        for (int i = 0; i < NC; i++) begin
            wr_q[i].delete();
            start_cnt[i] = 0;
        end
        wren_total = 0;
    endtask

    // Drive one qid + SQ random samples; optionally hold one core's FIFO full
    // for 3 cycles in front of word stall_at.
    task automatic send_pkt(input logic [31:0] qid, input int stall_core, input int stall_at);
        int t;
        pkt[0] = qid;
        for (int k = 1; k <= SQ; k++) pkt[k] = $urandom;
        for (int k = 0; k <= SQ; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = pkt[k];
            if (k == stall_at) begin
                core_src_full[stall_core] = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    chk("stall_sready", 32'(smp_sready), 32'd0);
                end
                core_src_full[stall_core] = 1'b0;
            end
            t = 0;
            do begin
                tick();
                t++;
            end while (!acc && t < 40);
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic check_pkt(input string tag, input int core);
        chk({tag, "_count"}, 32'(wr_q[core].size()), 32'(SQ + 1));
        for (int k = 0; k <= SQ && k < wr_q[core].size(); k++)
            chk({tag, "_word"}, wr_q[core][k], pkt[k]);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_s_ready"},   32'(s_ready), 32'd0);
        chk({tag, "_start"},     32'(core_start), 32'd0);
        chk({tag, "_wren"},      32'(core_src_wren), 32'd0);
        chk({tag, "_src_data"},  core_src_data, 32'd0);
        chk({tag, "_rden"},      32'(core_res_rden), 32'd0);
        chk({tag, "_m_valid"},   32'(m_valid), 32'd0);
        chk({tag, "_m_data"},    m_data, 32'd0);
        chk({tag, "_m_last"},    32'(m_last), 32'd0);
        chk({tag, "_n_disp"},    n_dispatched, 32'd0);
    endtask

    initial begin
        int t;
        rst           = 1'b1;
        s_valid       = 1'b0;
        s_data        = '0;
        core_busy     = '0;
        core_src_full = '0;
        m_ready       = 1'b0;
        pend_pop      = '0;
        clear_log();
        refresh();

        // ---- reset state ----
        repeat (3) tick();
        zero_check("reset");
        rst = 1'b0;
        tick();

        // ---- two packets to idle cores: core 0 then core 1 ----
        clear_log();
        send_pkt(32'h0000_00A1, 0, -1);
        check_pkt("pkt_a1_core0", 0);
        send_pkt(32'h0000_00A2, 0, -1);
        // Cores 0..2 report busy before the scheduler looks again.
        core_busy = 4'b0111;
        check_pkt("pkt_a2_core1", 1);
        chk("start_core0", 32'(start_cnt[0]), 32'd1);
        chk("start_core1", 32'(start_cnt[1]), 32'd1);
        chk("n_disp_2", n_dispatched, 32'd2);
        $display("step: two packets dispatched, n_dispatched=%0d", n_dispatched);

        // ---- only core 3 free: it gets the packet, then nothing is ready ----
        clear_log();
        send_pkt(32'h0000_00B3, 0, -1);
        check_pkt("pkt_b3_core3", 3);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("all_busy_sready", 32'(smp_sready), 32'd0);
        end
        s_valid = 1'b0;
        chk("all_busy_no_write", 32'(wren_total), 32'(SQ + 1));
        chk("start_core3", 32'(start_cnt[3]), 32'd1);
        chk("start_core2", 32'(start_cnt[2]), 32'd0);
        chk("n_disp_3", n_dispatched, 32'd3);
        $display("step: busy-mask packet on core 3, n_dispatched=%0d", n_dispatched);
        core_busy = 4'b0000;

        // ---- full-flag stall mid-packet on core 0 ----
        clear_log();
        send_pkt(32'h0000_00C0, 0, 2);
        check_pkt("pkt_c0_stall", 0);
        chk("stall_total_writes", 32'(wren_total), 32'(SQ + 1));
        chk("n_disp_4", n_dispatched, 32'd4);
        $display("step: stalled packet on core 0, writes=%0d", wren_total);

        // ---- collect results from cores 1 and 2 with toggling m_ready ----
        for (int k = 0; k < 3; k++) begin
            res_a[k] = $urandom;
            res_b[k] = $urandom;
            res_q[1].push_back(res_a[k]);
            res_q[2].push_back(res_b[k]);
        end
        refresh();
        m_ready = 1'b1;
        t = 0;
        while (out_q.size() < 6 && t < 60) begin
            tick();
            m_ready = ~m_ready;
            t++;
        end
        m_ready = 1'b1;
        chk("collect_count", 32'(out_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < out_q.size(); k++) begin
            chk("collect_data", out_q[k], (k < 3) ? res_a[k] : res_b[k - 3]);
            chk("collect_last", 32'(last_q[k]), 32'((k % 3) == 2));
        end
        $display("step: collected %0d result words", out_q.size());

        // ---- reset mid-packet, then a fresh packet goes to core 0 ----
        clear_log();
        pkt[0] = 32'h0000_00D1;
        pkt[1] = $urandom;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1;
            s_data  = pkt[k];
            t = 0;
            do begin
                tick();
                t++;
            end while (!acc && t < 40);
            if (!acc) chk("partial_timeout", 32'd0, 32'd1);
        end
        rst = 1'b1;
        tick();
        zero_check("midpkt_reset");
        rst     = 1'b0;
        s_valid = 1'b0;
        repeat (3) tick();
        clear_log();
        send_pkt(32'h0000_00E0, 0, -1);
        check_pkt("post_reset_core0", 0);
        chk("post_reset_n_disp", n_dispatched, 32'd1);
        $display("step: post-reset packet on core 0, n_dispatched=%0d", n_dispatched);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
